// File: rtl/frogger_key_cmd.sv
// frogger_key_cmd: PS/2 set-2 keyboard front end for the frogger top level.
// Filters the PS/2 clock, receives 11-bit frames, decodes the E0/F0 prefixes
// and turns arrow-key make codes into a one-hot motion command. The command
// is held until the next refr_tick.
// Optional build macro WASD_KEYS_EN: also map the plain W/S/A/D make codes
// to up/down/left/right.
//
// state   | meaning
// --------+-------------------------------------------
// IDLE    | waiting for a prefix or a plain make code
// EXT     | E0 seen, next byte is an extended code
// BRK     | F0 seen, next byte is a released key
// EXT_BRK | E0 F0 seen, next byte is a released key
module frogger_key_cmd #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2c,
   input  logic       ps2d,
   input  logic       refr_tick,
   output logic [3:0] motion_cmd,
   output logic       byte_valid,
   output logic       parity_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC - 1);

   localparam logic [3:0] CMD_UP    = 4'b1000;
   localparam logic [3:0] CMD_DOWN  = 4'b0100;
   localparam logic [3:0] CMD_LEFT  = 4'b0010;
   localparam logic [3:0] CMD_RIGHT = 4'b0001;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } dec_state_t;

   logic          ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [8:0]    shift_q, shift_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          byte_valid_q, byte_valid_d;
   logic          parity_err_q, parity_err_d;
   dec_state_t    state_q, state_d;
   logic          set_en;
   logic [3:0]    set_code;
   logic [3:0]    motion_cmd_q, motion_cmd_d;

   // Two-flop synchronisers for both PS/2 lines.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps2c_s1_q <= 1'b0;
         ps2c_s2_q <= 1'b0;
         ps2d_s1_q <= 1'b0;
         ps2d_s2_q <= 1'b0;
      end else begin
         ps2c_s1_q <= ps2c;
         ps2c_s2_q <= ps2c_s1_q;
         ps2d_s1_q <= ps2d;
         ps2d_s2_q <= ps2d_s1_q;
      end
   end

   // Glitch filter: the level flips only after FILTER_LEN differing samples in a row.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (ps2c_s2_q != filt_q) begin
         if (filt_cnt_q == FILT_MAX) begin
            filt_d = ps2c_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
      fall = filt_q & ~filt_d;
   end

   // Frame receiver with stall timeout; timeout is a down-counter that only
   // runs while a frame is in progress and the filtered clock sits high.
   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      to_cnt_d     = to_cnt_q;
      rx_byte_d    = rx_byte_q;
      byte_valid_d = 1'b0;
      parity_err_d = 1'b0;
      if (bit_cnt_q == 4'd0 || !filt_q) begin
         to_cnt_d = TO_MAX;
      end else if (to_cnt_q == '0) begin
         to_cnt_d  = TO_MAX;
         bit_cnt_d = 4'd0;
      end else begin
         to_cnt_d = to_cnt_q - 1'b1;
      end
      if (fall) begin
         to_cnt_d = TO_MAX;
         if (bit_cnt_q == 4'd0) begin
            // A high start bit is noise; stay aligned on the next low one.
            if (!ps2d_s2_q) begin
               bit_cnt_d = 4'd1;
               shift_d   = '0;
            end
         end else if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            if ((^shift_q) && ps2d_s2_q) begin
               byte_valid_d = 1'b1;
               rx_byte_d    = shift_q[7:0];
            end else begin
               parity_err_d = 1'b1;
            end
         end else begin
            shift_d   = {ps2d_s2_q, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end
   end

   // Scan-code decoder, stepped once per good byte.
   always_comb begin
      state_d  = state_q;
      set_en   = 1'b0;
      set_code = 4'b0000;
      if (byte_valid_q) begin
         case (state_q)
            IDLE: begin
               case (rx_byte_q)
                  8'hE0:   state_d = EXT;
                  8'hF0:   state_d = BRK;
`ifdef WASD_KEYS_EN
                  8'h1D:   begin set_en = 1'b1; set_code = CMD_UP;    end
                  8'h1B:   begin set_en = 1'b1; set_code = CMD_DOWN;  end
                  8'h1C:   begin set_en = 1'b1; set_code = CMD_LEFT;  end
                  8'h23:   begin set_en = 1'b1; set_code = CMD_RIGHT; end
`endif
                  default: state_d = IDLE;
               endcase
            end
            EXT: begin
               state_d = IDLE;
               case (rx_byte_q)
                  8'hF0:   state_d = EXT_BRK;
                  8'h75:   begin set_en = 1'b1; set_code = CMD_UP;    end
                  8'h72:   begin set_en = 1'b1; set_code = CMD_DOWN;  end
                  8'h6B:   begin set_en = 1'b1; set_code = CMD_LEFT;  end
                  8'h74:   begin set_en = 1'b1; set_code = CMD_RIGHT; end
                  default: state_d = IDLE;
               endcase
            end
            BRK:     state_d = IDLE;
            EXT_BRK: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Command latch: a new key overrides, refr_tick consumes, set beats tick.
   always_comb begin
      motion_cmd_d = motion_cmd_q;
      if (set_en) begin
         motion_cmd_d = set_code;
      end else if (refr_tick) begin
         motion_cmd_d = 4'b0000;
      end
   end

   // State registers for filter, receiver, decoder and command.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_q       <= 1'b0;
         filt_cnt_q   <= '0;
         bit_cnt_q    <= 4'd0;
         shift_q      <= '0;
         to_cnt_q     <= TO_MAX;
         rx_byte_q    <= '0;
         byte_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         state_q      <= IDLE;
         motion_cmd_q <= 4'b0000;
      end else begin
         filt_q       <= filt_d;
         filt_cnt_q   <= filt_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         to_cnt_q     <= to_cnt_d;
         rx_byte_q    <= rx_byte_d;
         byte_valid_q <= byte_valid_d;
         parity_err_q <= parity_err_d;
         state_q      <= state_d;
         motion_cmd_q <= motion_cmd_d;
      end
   end

   assign motion_cmd = motion_cmd_q;
   assign byte_valid = byte_valid_q;
   assign parity_err = parity_err_q;

endmodule

// File: tb/tb_frogger_key_cmd.sv
// Bench for frogger_key_cmd: drives PS/2 frames, queues the expected pulse
// kind and resulting command per frame, and a monitor pops and compares.
module tb_frogger_key_cmd;

   localparam int TO_CYC = 500;
   localparam int HALF   = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2c = 1'b1;
   logic       ps2d = 1'b1;
   logic       refr_tick = 1'b0;
   logic [3:0] motion_cmd;
   logic       byte_valid;
   logic       parity_err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       err;
      logic [3:0] cmd;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   logic       pend = 1'b0;
   logic [3:0] pend_cmd = 4'b0000;

`ifdef WASD_KEYS_EN
   localparam logic [3:0] W_CMD = 4'b1000;
`else
   localparam logic [3:0] W_CMD = 4'b0000;
`endif

   frogger_key_cmd #(.FILTER_LEN(8), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2c       (ps2c),
      .ps2d       (ps2d),
      .refr_tick  (refr_tick),
      .motion_cmd (motion_cmd),
      .byte_valid (byte_valid),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Monitor: every pulse must match the head of the scoreboard, and the
   // command one cycle later must match what that byte should leave behind.
   always @(negedge clk) begin
      if (pend) begin
         check_val("cmd_after_byte", {4'b0, motion_cmd}, {4'b0, pend_cmd});
         pend = 1'b0;
      end
      if (reset && (byte_valid || parity_err)) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_pulse", {6'b0, byte_valid, parity_err}, 8'h00);
         end else begin
            sb_entry_t e;
            e = sb_q.pop_front();
            check_val("pulse_kind", {6'b0, byte_valid, parity_err}, e.err ? 8'h01 : 8'h02);
            pend     = 1'b1;
            pend_cmd = e.cmd;
         end
      end
   end

   task automatic wait_cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic ps2_bit(input logic b, input logic tick_en);
      ps2d = b;
      wait_cyc(HALF);
      ps2c = 1'b0;
      for (int i = 0; i < HALF; i++) begin
         @(negedge clk);
         refr_tick = tick_en & byte_valid;
      end
      refr_tick = 1'b0;
      ps2c = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] data, input logic bad_par,
                            input logic [3:0] exp_cmd, input logic tick_en);
      logic [10:0] fr;
      sb_entry_t   e;
      fr = {1'b1, (~^data) ^ bad_par, data, 1'b0};
      e.err = bad_par;
      e.cmd = exp_cmd;
      sb_q.push_back(e);
      for (int i = 0; i < 11; i++) ps2_bit(fr[i], tick_en);
      wait_cyc(HALF);
   endtask

   task automatic do_tick();
      @(negedge clk);
      refr_tick = 1'b1;
      @(negedge clk);
      refr_tick = 1'b0;
      check_val("cmd_after_tick", {4'b0, motion_cmd}, 8'h00);
   endtask

   initial begin
      wait_cyc(3);
      #1;
      check_val("rst_cmd", {4'b0, motion_cmd}, 8'h00);
      check_val("rst_bv", {7'b0, byte_valid}, 8'h00);
      check_val("rst_pe", {7'b0, parity_err}, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      wait_cyc(30);

      // Stray clock pulse with data high must not start a frame.
      ps2_bit(1'b1, 1'b0);
      wait_cyc(HALF);

      send_byte(8'hE0, 1'b0, 4'b0000, 1'b0);
      send_byte(8'h75, 1'b0, 4'b1000, 1'b0);
      wait_cyc(10);
      check_val("up_hold", {4'b0, motion_cmd}, 8'h08);
      do_tick();

      // Up release, then left.
      send_byte(8'hE0, 1'b0, 4'b0000, 1'b0);
      send_byte(8'hF0, 1'b0, 4'b0000, 1'b0);
      send_byte(8'h75, 1'b0, 4'b0000, 1'b0);
      send_byte(8'hE0, 1'b0, 4'b0000, 1'b0);
      send_byte(8'h6B, 1'b0, 4'b0010, 1'b0);
      do_tick();

      // Plain release absorbs E0; unknown extended code returns to IDLE.
      send_byte(8'hF0, 1'b0, 4'b0000, 1'b0);
      send_byte(8'hE0, 1'b0, 4'b0000, 1'b0);
      send_byte(8'h75, 1'b0, 4'b0000, 1'b0);
      send_byte(8'hE0, 1'b0, 4'b0000, 1'b0);
      send_byte(8'h12, 1'b0, 4'b0000, 1'b0);
      send_byte(8'h72, 1'b0, 4'b0000, 1'b0);

      // Bad parity is dropped without disturbing EXT.
      send_byte(8'hE0, 1'b0, 4'b0000, 1'b0);
      send_byte(8'h6B, 1'b1, 4'b0000, 1'b0);
      send_byte(8'h6B, 1'b0, 4'b0010, 1'b0);
      do_tick();

      // Typematic repeat, then set coinciding with refr_tick.
      send_byte(8'hE0, 1'b0, 4'b0000, 1'b0);
      send_byte(8'h75, 1'b0, 4'b1000, 1'b0);
      send_byte(8'hE0, 1'b0, 4'b1000, 1'b0);
      send_byte(8'h75, 1'b0, 4'b1000, 1'b0);
      send_byte(8'hE0, 1'b0, 4'b1000, 1'b0);
      send_byte(8'h74, 1'b0, 4'b0001, 1'b1);
      wait_cyc(5);
      check_val("set_wins", {4'b0, motion_cmd}, 8'h01);
      do_tick();

      // Partial frame then stall past the timeout.
      for (int i = 0; i < 6; i++) ps2_bit(i[0], 1'b0);
      wait_cyc(TO_CYC + 50);
      send_byte(8'hE0, 1'b0, 4'b0000, 1'b0);
      send_byte(8'h72, 1'b0, 4'b0100, 1'b0);
      check_val("down_hold", {4'b0, motion_cmd}, 8'h04);

      // Reset in the middle of a frame clears at once.
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_bit(1'b0, 1'b0);
      reset = 1'b0;
      #1;
      check_val("midrst_cmd", {4'b0, motion_cmd}, 8'h00);
      check_val("midrst_bv", {7'b0, byte_valid}, 8'h00);
      check_val("midrst_pe", {7'b0, parity_err}, 8'h00);
      wait_cyc(4);
      reset = 1'b1;
      wait_cyc(30);

      // WASD keys: only active with the build macro.
      send_byte(8'h1D, 1'b0, W_CMD, 1'b0);
      send_byte(8'hF0, 1'b0, W_CMD, 1'b0);
      send_byte(8'h1D, 1'b0, W_CMD, 1'b0);
      send_byte(8'hE0, 1'b0, W_CMD, 1'b0);
      send_byte(8'h6B, 1'b0, 4'b0010, 1'b0);
      do_tick();

      wait_cyc(5);
      check_val("sb_empty", 8'(sb_q.size()), 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
